mul_share_rr_sched: RTL and testbench

- Round-robin scheduler that time-shares one signed×unsigned multiplier (13-bit signed × 6-bit unsigned → 18-bit) among N_REQ requesters in a resource-constrained dense layer.
- Arbitrates operand requests and registers the operands into the shared multiplier.
- Returns each tagged product through a single backpressured result port.
- Sits between per-neuron accumulator engines and the shared multiplier datapath.

---
 rtl/mul_share_rr_sched.sv | 158 +++++++++++++++
 tb/tb_mul_share_rr_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_rr_sched.sv
// Round-robin scheduler sharing one signed x unsigned multiplier among N_REQ requesters.
// Optional feature: define MUL_SHARE_SAT_EN to saturate the product to the signed OUT_W range.
module mul_share_rr_sched #(
    parameter int N_REQ = 4,
    parameter int A_W   = 13,
    parameter int B_W   = 6,
    parameter int OUT_W = 18,
    parameter int TAG_W = 4
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*A_W-1:0]       req_a,
    input  logic [N_REQ*B_W-1:0]       req_b,
    input  logic [N_REQ*TAG_W-1:0]     req_tag,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUT_W-1:0]           res_data,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic [TAG_W-1:0]           res_tag,
    output logic                       busy
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int PW   = A_W + B_W + 1;

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              s0_valid_q, s0_valid_d;
    logic [A_W-1:0]    s0_a_q, s0_a_d;
    logic [B_W-1:0]    s0_b_q, s0_b_d;
    logic [ID_W-1:0]   s0_id_q, s0_id_d;
    logic [TAG_W-1:0]  s0_tag_q, s0_tag_d;
    logic              res_valid_q, res_valid_d;
    logic [OUT_W-1:0]  res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;

    logic              adv;
    logic              win_any;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   cand;
    logic              xfer;

    logic signed [PW-1:0] prod_full;
    logic [OUT_W-1:0]     prod_out;

    assign adv  = !res_valid_q || res_ready;
    // Gating with ap_rst_n keeps req_ready low while reset is asserted.
    assign xfer = win_any && adv && ap_rst_n;

    // Walk the ring starting one past the last winner; first valid requester wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + ID_W'(1);
            if (!win_any && req_valid[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = xfer && (win_idx == ID_W'(gi));
        end
    endgenerate

    assign prod_full = PW'($signed(s0_a_q)) * PW'($signed({1'b0, s0_b_q}));

    generate
        if (OUT_W >= PW) begin : g_wide
            assign prod_out = OUT_W'(prod_full);
        end else begin : g_narrow
`ifdef MUL_SHARE_SAT_EN
            localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            always_comb begin
                prod_out = prod_full[OUT_W-1:0];
                if (prod_full > SAT_MAX) begin
                    prod_out = SAT_MAX[OUT_W-1:0];
                end else if (prod_full < SAT_MIN) begin
                    prod_out = SAT_MIN[OUT_W-1:0];
                end
            end
`else
            assign prod_out = prod_full[OUT_W-1:0];
`endif
        end
    endgenerate

    always_comb begin
        ptr_d       = ptr_q;
        s0_valid_d  = s0_valid_q;
        s0_a_d      = s0_a_q;
        s0_b_d      = s0_b_q;
        s0_id_d     = s0_id_q;
        s0_tag_d    = s0_tag_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_tag_d   = res_tag_q;
        if (adv) begin
            s0_valid_d  = xfer;
            res_valid_d = s0_valid_q;
            if (xfer) begin
                ptr_d    = win_idx;
                s0_a_d   = req_a[win_idx*A_W +: A_W];
                s0_b_d   = req_b[win_idx*B_W +: B_W];
                s0_id_d  = win_idx;
                s0_tag_d = req_tag[win_idx*TAG_W +: TAG_W];
            end
            // An empty S0 leaves the previous result fields in place.
            if (s0_valid_q) begin
                res_data_d = prod_out;
                res_id_d   = s0_id_q;
                res_tag_d  = s0_tag_q;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q       <= ID_W'(N_REQ - 1);
            s0_valid_q  <= 1'b0;
            s0_a_q      <= '0;
            s0_b_q      <= '0;
            s0_id_q     <= '0;
            s0_tag_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_tag_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s0_valid_q  <= s0_valid_d;
            s0_a_q      <= s0_a_d;
            s0_b_q      <= s0_b_d;
            s0_id_q     <= s0_id_d;
            s0_tag_q    <= s0_tag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_tag   = res_tag_q;
    assign busy      = s0_valid_q || res_valid_q;

endmodule

// File: tb/tb_mul_share_rr_sched.sv
// Self-checking bench for mul_share_rr_sched: scoreboard of expected products plus
// per-scenario checks on a default instance and a narrow (OUT_W=12) instance.
`timescale 1ns/1ps
module tb_mul_share_rr_sched;

    localparam int N  = 4;
    localparam int AW = 13;
    localparam int BW = 6;
    localparam int OW = 18;
    localparam int TW = 4;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_a;
    logic [N*BW-1:0]   req_b;
    logic [N*TW-1:0]   req_tag;
    logic              res_valid;
    logic              res_ready;
    logic [OW-1:0]     res_data;
    logic [1:0]        res_id;
    logic [TW-1:0]     res_tag;
    logic              busy;

    logic [AW-1:0] a_v [N];
    logic [BW-1:0] b_v [N];
    logic [TW-1:0] t_v [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign req_a[gi*AW +: AW]   = a_v[gi];
            assign req_b[gi*BW +: BW]   = b_v[gi];
            assign req_tag[gi*TW +: TW] = t_v[gi];
        end
    endgenerate

    mul_share_rr_sched #(.N_REQ(N), .A_W(AW), .B_W(BW), .OUT_W(OW), .TAG_W(TW)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_tag(res_tag),
        .busy(busy)
    );

    // Narrow instance: 13x7-bit product squeezed into 12 bits.
    logic [1:0]     n_req_valid;
    logic [1:0]     n_req_ready;
    logic [2*AW-1:0] n_req_a;
    logic [2*BW-1:0] n_req_b;
    logic [2*TW-1:0] n_req_tag;
    logic           n_res_valid;
    logic           n_res_ready;
    logic [11:0]    n_res_data;
    logic [0:0]     n_res_id;
    logic [TW-1:0]  n_res_tag;
    logic           n_busy;

    mul_share_rr_sched #(.N_REQ(2), .A_W(AW), .B_W(BW), .OUT_W(12), .TAG_W(TW)) dut12 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(n_req_valid), .req_ready(n_req_ready),
        .req_a(n_req_a), .req_b(n_req_b), .req_tag(n_req_tag),
        .res_valid(n_res_valid), .res_ready(n_res_ready),
        .res_data(n_res_data), .res_id(n_res_id), .res_tag(n_res_tag),
        .busy(n_busy)
    );

    typedef struct packed {
        logic [OW-1:0] data;
        logic [1:0]    id;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_got;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [OW-1:0] model_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
        longint sa;
        longint p;
        sa = longint'($signed(a));
        p  = sa * longint'({1'b0, b});
        return p[OW-1:0];
    endfunction

    // Scoreboard: push on accepted request, pop on accepted result.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            n_checks++;
            if (!$onehot0(req_ready)) begin
                n_fail++;
                $display("FAIL ready_onehot0: req_ready=%b", req_ready);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_e.data = model_prod(a_v[i], b_v[i]);
                    mon_e.id   = 2'(i);
                    mon_e.tag  = t_v[i];
                    sb.push_back(mon_e);
                end
            end
            if (res_valid && res_ready) begin
                n_checks++;
                mon_got = {res_data, res_id, res_tag};
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got data=%h id=%0d tag=%0d with empty scoreboard",
                             res_data, res_id, res_tag);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_got !== mon_e) begin
                        n_fail++;
                        $display("FAIL sb_result: got data=%h id=%0d tag=%0d, expected data=%h id=%0d tag=%0d",
                                 res_data, res_id, res_tag, mon_e.data, mon_e.id, mon_e.tag);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_v[i] = AW'(i + 1);
            b_v[i] = BW'(i + 2);
            t_v[i] = TW'(i + 8);
        end
        req_valid = 4'hF;
        repeat (3) tick();
        @(negedge ap_clk);
        n_checks++;
        if (req_ready !== 4'b0000 || res_valid !== 1'b0 || busy !== 1'b0 || res_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: req_ready=%b res_valid=%b busy=%b res_data=%h, expected 0000/0/0/0",
                     req_ready, res_valid, busy, res_data);
        end
        tick();
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: req_ready=%b, expected 0001", req_ready);
        end
        tick();
        req_valid = 4'h0;
        repeat (4) tick();
        $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_single();
        a_v[0] = AW'(-5);
        b_v[0] = 6'd7;
        t_v[0] = 4'd3;
        req_valid = 4'b0001;
        @(negedge ap_clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: req_ready=%b, expected 0001", req_ready);
        end
        tick();
        req_valid = 4'h0;
        @(negedge ap_clk);
        n_checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t1: busy=%b res_valid=%b, expected 1/0", busy, res_valid);
        end
        @(negedge ap_clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 18'h3FFDD || res_id !== 2'd0 || res_tag !== 4'd3) begin
            n_fail++;
            $display("FAIL single_result: valid=%b data=%h id=%0d tag=%0d, expected 1/3ffdd/0/3",
                     res_valid, res_data, res_id, res_tag);
        end
        tick();
        repeat (3) tick();
        $display("test_single done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_round_robin();
        // Park the pointer on requester 3 so the next sweep begins at 0.
        req_valid = 4'b1000;
        @(negedge ap_clk);
        tick();
        req_valid = 4'h0;
        repeat (3) tick();
        for (int i = 0; i < N; i++) begin
            a_v[i] = AW'($urandom);
            b_v[i] = BW'($urandom);
            t_v[i] = TW'(i + 4);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            @(negedge ap_clk);
            if (k < 8) begin
                n_checks++;
                if (req_ready !== 4'(1 << (k % 4))) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d]: req_ready=%b, expected %b", k, req_ready, 4'(1 << (k % 4)));
                end
            end
            if (k >= 2) begin
                n_checks++;
                if (res_valid !== 1'b1 || res_id !== 2'((k - 2) % 4)) begin
                    n_fail++;
                    $display("FAIL rr_result[%0d]: res_valid=%b res_id=%0d, expected 1/%0d",
                             k, res_valid, res_id, (k - 2) % 4);
                end
            end
            tick();
            if (k == 7) req_valid = 4'h0;
            for (int i = 0; i < N; i++) begin
                a_v[i] = AW'($urandom);
                b_v[i] = BW'($urandom);
            end
        end
        repeat (3) tick();
        $display("test_round_robin done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_backpressure();
        logic [OW+2+TW-1:0] held;
        logic [1:0] held_id;
        for (int i = 0; i < N; i++) begin
            a_v[i] = AW'($urandom);
            b_v[i] = BW'($urandom);
            t_v[i] = TW'(i + 1);
        end
        req_valid = 4'b0101;
        repeat (3) tick();
        res_ready = 1'b0;
        @(negedge ap_clk);
        held = {res_data, res_id, res_tag};
        held_id = res_id;
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_valid_at_stall: res_valid=%b, expected 1", res_valid);
        end
        for (int s = 0; s < 5; s++) begin
            tick();
            @(negedge ap_clk);
            n_checks++;
            if (res_valid !== 1'b1 || {res_data, res_id, res_tag} !== held || req_ready !== 4'b0000 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: valid=%b res=%h ready=%b busy=%b, expected 1/%h/0000/1",
                         s, res_valid, {res_data, res_id, res_tag}, req_ready, busy, held);
            end
        end
        tick();
        res_ready = 1'b1;
        @(negedge ap_clk);
        n_checks++;
        if (res_valid !== 1'b1 || {res_data, res_id, res_tag} !== held) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b res=%h, expected 1/%h", res_valid, {res_data, res_id, res_tag}, held);
        end
        tick();
        @(negedge ap_clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== ((held_id == 2'd0) ? 2'd2 : 2'd0)) begin
            n_fail++;
            $display("FAIL bp_next: valid=%b id=%0d, expected 1/%0d", res_valid, res_id,
                     (held_id == 2'd0) ? 2 : 0);
        end
        tick();
        req_valid = 4'h0;
        repeat (4) tick();
        @(negedge ap_clk);
        n_checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: pending=%0d busy=%b, expected 0/0", sb.size(), busy);
        end
        tick();
        $display("test_backpressure done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_extremes();
        int ta [3] = '{-4096, 4095, 1234};
        int tb [3] = '{63, 63, 0};
        int te [3] = '{-258048, 257985, 0};
        bit got;
        for (int j = 0; j < 3; j++) begin
            a_v[1] = AW'(ta[j]);
            b_v[1] = BW'(tb[j]);
            t_v[1] = TW'(j);
            req_valid = 4'b0010;
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge ap_clk);
                if (req_ready[1]) got = 1'b1;
                else tick();
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL ext_grant_timeout[%0d]: req_ready=%b, expected bit1 within 10 cycles", j, req_ready);
            end
            tick();
            req_valid = 4'h0;
            @(negedge ap_clk);
            @(negedge ap_clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== OW'(te[j]) || res_id !== 2'd1) begin
                n_fail++;
                $display("FAIL ext_result[%0d]: valid=%b data=%h id=%0d, expected 1/%h/1",
                         j, res_valid, res_data, res_id, OW'(te[j]));
            end
            tick();
            repeat (2) tick();
        end
        $display("test_extremes done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_narrow();
        int na [2] = '{100, -100};
`ifdef MUL_SHARE_SAT_EN
        logic [11:0] ne [2] = '{12'h7FF, 12'h800};
`else
        logic [11:0] ne [2] = '{12'd2204, 12'd1892};
`endif
        for (int j = 0; j < 2; j++) begin
            n_req_a[AW +: AW] = AW'(na[j]);
            n_req_b[BW +: BW] = 6'd63;
            n_req_tag[TW +: TW] = TW'(j + 5);
            n_req_valid = 2'b10;
            @(negedge ap_clk);
            n_checks++;
            if (n_req_ready !== 2'b10) begin
                n_fail++;
                $display("FAIL narrow_ready[%0d]: req_ready=%b, expected 10", j, n_req_ready);
            end
            tick();
            n_req_valid = 2'b00;
            @(negedge ap_clk);
            @(negedge ap_clk);
            n_checks++;
            if (n_res_valid !== 1'b1 || n_res_data !== ne[j] || n_res_id !== 1'b1 || n_res_tag !== TW'(j + 5)) begin
                n_fail++;
                $display("FAIL narrow_result[%0d]: valid=%b data=%h id=%0d tag=%0d, expected 1/%h/1/%0d",
                         j, n_res_valid, n_res_data, n_res_id, n_res_tag, ne[j], j + 5);
            end
            tick();
            repeat (2) tick();
        end
        $display("test_narrow done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    initial begin
        req_valid   = '0;
        res_ready   = 1'b1;
        n_req_valid = '0;
        n_req_a     = '0;
        n_req_b     = '0;
        n_req_tag   = '0;
        n_res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
            t_v[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_extremes();
        test_narrow();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d results never produced, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
